// File: rtl/exc_request_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : exc_request_ctrl
// Purpose  : Request side of the processor exception handshake. Interrupt
//            rising edges are latched as pending. The lowest-index unmasked
//            pending source is forwarded to the exception unit as Exc plus a
//            4-bit EStatus cause code. The request is held until ExcAck.
//            Further requests are blocked until ERet and a drain holdoff.
// Ports    : clk       - rising-edge clock
//            reset     - asynchronous active-low reset
//            irq       - interrupt lines, a rising edge is a new event
//            irq_mask  - 1 = source may raise Exc (pending still latches)
//            ExcAck    - exception unit fetched the vector
//            ERet      - handler returned, 1-cycle pulse
//            Exc       - exception request
//            EStatus   - cause code (source i -> i+1, 0 = none)
//            pending   - latched, not-yet-serviced events
//            busy      - 1 while in REQ, HANDLER or DRAIN
// Revision : 1.0 - initial release
// ============================================================================
module exc_request_ctrl #(
  parameter int NSRC    = 4,
  parameter int HOLDOFF = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq,
  input  logic [NSRC-1:0] irq_mask,
  input  logic            ExcAck,
  input  logic            ERet,
  output logic            Exc,
  output logic [3:0]      EStatus,
  output logic [NSRC-1:0] pending,
  output logic            busy
);

  localparam int CNT_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_HANDLER = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              exc_q, exc_d;
  logic [3:0]        estatus_q, estatus_d;
  logic [NSRC-1:0]   pending_q, pending_d;
  logic [NSRC-1:0]   irq_q;
  logic [NSRC-1:0]   svc_q, svc_d;   // one-hot serviced source
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;

  logic [NSRC-1:0]   rise;
  logic [NSRC-1:0]   cand;
  logic [NSRC-1:0]   sel_oh;
  logic [NSRC-1:0]   clr;
  logic [3:0]        sel;

  assign rise   = irq & ~irq_q;
  assign cand   = pending_q & irq_mask;
  // Isolate the lowest set bit: index 0 has the highest priority.
  assign sel_oh = cand & (~cand + 1'b1);

  always_comb begin
    sel = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (cand[i]) sel = 4'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    exc_d     = exc_q;
    estatus_d = estatus_q;
    svc_d     = svc_q;
    cnt_d     = cnt_q;
    clr       = '0;

    case (state_q)
      S_IDLE: begin
        if (|cand) begin
          state_d   = S_REQ;
          exc_d     = 1'b1;
          estatus_d = sel + 4'd1;
          svc_d     = sel_oh;
        end
      end
      S_REQ: begin
        // ExcAck takes precedence; an ERet in the same cycle is ignored.
        if (ExcAck) begin
          state_d = S_HANDLER;
          exc_d   = 1'b0;
          clr     = svc_q;
        end
      end
      S_HANDLER: begin
        if (ERet) begin
          state_d   = S_DRAIN;
          cnt_d     = CNT_W'(HOLDOFF - 1);
          estatus_d = 4'd0;
        end
      end
      S_DRAIN: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A new edge on the serviced source in the ExcAck cycle keeps it pending.
    pending_d = (pending_q & ~clr) | rise;
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      exc_q     <= 1'b0;
      estatus_q <= 4'd0;
      pending_q <= '0;
      irq_q     <= '0;
      svc_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      exc_q     <= exc_d;
      estatus_q <= estatus_d;
      pending_q <= pending_d;
      irq_q     <= irq;
      svc_q     <= svc_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
    end
  end

  assign Exc     = exc_q;
  assign EStatus = estatus_q;
  assign pending = pending_q;
  assign busy    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_exc_request_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_exc_request_ctrl
// Purpose  : Directed self-checking bench for exc_request_ctrl with
//            hand-computed expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exc_request_ctrl;

  logic       clk;
  logic       reset;
  logic [3:0] irq;
  logic [3:0] irq_mask;
  logic       ExcAck;
  logic       ERet;
  logic       Exc;
  logic [3:0] EStatus;
  logic [3:0] pending;
  logic       busy;

  int n_checks;
  int n_fail;

  exc_request_ctrl #(.NSRC(4), .HOLDOFF(3)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .irq      (irq),
    .irq_mask (irq_mask),
    .ExcAck   (ExcAck),
    .ERet     (ERet),
    .Exc      (Exc),
    .EStatus  (EStatus),
    .pending  (pending),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // One clock edge, then settle 1 time unit past it.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    irq      = 4'b0000;
    irq_mask = 4'b1111;
    ExcAck   = 1'b0;
    ERet     = 1'b0;

    #3;
    check("rst_exc",     32'(Exc),     32'h0);
    check("rst_estatus", 32'(EStatus), 32'h0);
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_busy",    32'(busy),    32'h0);
    #14 reset = 1'b1;
    step(1);

    // Test 1: single source, full handshake
    irq = 4'b0001;
    step(1);
    check("t1_pending",  32'(pending), 32'h1);
    check("t1_exc_early",32'(Exc),     32'h0);
    irq = 4'b0000;
    step(1);
    check("t1_exc",      32'(Exc),     32'h1);
    check("t1_estatus",  32'(EStatus), 32'h1);
    check("t1_busy",     32'(busy),    32'h1);
    ExcAck = 1'b1;
    step(1);
    ExcAck = 1'b0;
    check("t1_ack_exc",  32'(Exc),     32'h0);
    check("t1_ack_pend", 32'(pending), 32'h0);
    check("t1_ack_est",  32'(EStatus), 32'h1);
    ERet = 1'b1;
    step(1);
    ERet = 1'b0;
    check("t1_eret_est", 32'(EStatus), 32'h0);
    step(2);
    check("t1_drain_busy", 32'(busy), 32'h1);
    step(1);
    check("t1_idle_busy",  32'(busy), 32'h0);

    // Test 2: two sources together, priority and drain latency
    irq = 4'b0110;
    step(1);
    irq = 4'b0000;
    check("t2_pending",  32'(pending), 32'h6);
    step(1);
    check("t2_estatus",  32'(EStatus), 32'h2);
    ExcAck = 1'b1;
    step(1);
    ExcAck = 1'b0;
    check("t2_ack_pend", 32'(pending), 32'h4);
    check("t2_handler_exc", 32'(Exc),  32'h0);
    ERet = 1'b1;
    step(1);
    ERet = 1'b0;
    step(3);
    check("t2_holdoff_exc", 32'(Exc),  32'h0);
    step(1);
    check("t2_exc2",     32'(Exc),     32'h1);
    check("t2_estatus2", 32'(EStatus), 32'h3);

    // Test 4: higher-priority event while in REQ does not alter the request
    irq = 4'b0001;
    irq_mask = 4'b0000;
    step(1);
    irq = 4'b0000;
    irq_mask = 4'b1111;
    check("t4_exc_held", 32'(Exc),     32'h1);
    check("t4_est_held", 32'(EStatus), 32'h3);
    check("t4_pending",  32'(pending), 32'h5);
    ExcAck = 1'b1;
    step(1);
    ExcAck = 1'b0;
    check("t4_ack_pend", 32'(pending), 32'h1);
    ERet = 1'b1;
    step(1);
    ERet = 1'b0;
    step(4);
    check("t4_next_est", 32'(EStatus), 32'h1);
    ExcAck = 1'b1;
    step(1);
    ExcAck = 1'b0;
    ERet = 1'b1;
    step(1);
    ERet = 1'b0;
    step(3);
    check("t4_idle",     32'(busy),    32'h0);

    // Test 5a: ERet in IDLE is ignored
    ERet = 1'b1;
    step(1);
    ERet = 1'b0;
    check("t5_eret_idle", 32'(busy),   32'h0);

    // Test 3: masked source latches pending but raises nothing
    irq_mask = 4'b0111;
    irq = 4'b1000;
    step(1);
    irq = 4'b0000;
    check("t3_pending",  32'(pending), 32'h8);
    step(1);
    check("t3_masked_exc", 32'(Exc),   32'h0);
    check("t3_masked_busy",32'(busy),  32'h0);
    irq_mask = 4'b1111;
    step(1);
    check("t3_exc",      32'(Exc),     32'h1);
    check("t3_estatus",  32'(EStatus), 32'h4);

    // Test 5b: re-rise of serviced source in the ExcAck cycle keeps it pending
    ExcAck = 1'b1;
    irq = 4'b1000;
    step(1);
    ExcAck = 1'b0;
    irq = 4'b0000;
    check("t5_set_wins", 32'(pending), 32'h8);
    check("t5_ack_exc",  32'(Exc),     32'h0);
    // ExcAck in HANDLER is ignored
    ExcAck = 1'b1;
    step(1);
    ExcAck = 1'b0;
    check("t5_hdl_busy", 32'(busy),    32'h1);
    check("t5_hdl_est",  32'(EStatus), 32'h4);
    check("t5_hdl_exc",  32'(Exc),     32'h0);
    ERet = 1'b1;
    step(1);
    ERet = 1'b0;
    step(4);
    check("t5_rereq_est", 32'(EStatus), 32'h4);

    // ExcAck and ERet together in REQ: only ExcAck acts
    ExcAck = 1'b1;
    ERet = 1'b1;
    step(1);
    ExcAck = 1'b0;
    ERet = 1'b0;
    check("both_exc",    32'(Exc),     32'h0);
    check("both_est",    32'(EStatus), 32'h4);
    step(1);
    check("both_still_handler", 32'(EStatus), 32'h4);
    check("both_busy",   32'(busy),    32'h1);
    ERet = 1'b1;
    step(1);
    ERet = 1'b0;
    step(3);

    // Test 6: async reset in REQ
    irq = 4'b0010;
    step(1);
    irq = 4'b0000;
    step(1);
    check("t6_pre_exc",  32'(Exc),     32'h1);
    check("t6_pre_est",  32'(EStatus), 32'h2);
    #2 reset = 1'b0;
    #1;
    check("t6_rst_exc",  32'(Exc),     32'h0);
    check("t6_rst_est",  32'(EStatus), 32'h0);
    check("t6_rst_pend", 32'(pending), 32'h0);
    check("t6_rst_busy", 32'(busy),    32'h0);
    #3 reset = 1'b1;
    step(2);
    check("t6_rel_exc",  32'(Exc),     32'h0);
    check("t6_rel_busy", 32'(busy),    32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
